uart_rx_frame: RTL and testbench

- UART receive framer; sits directly downstream of baud_rate_generator and consumes its one-cycle tick as the oversampling strobe.
- Synchronises the serial rx line, finds the start bit, samples each bit at mid-point, checks the stop bit, and presents each byte on a valid/ready output register with overrun and framing flags.
- Feeds the byte consumer (FIFO/register file) of the UART receiver.

---
 rtl/uart_rx_pkg.sv | 6 +
 rtl/uart_rx_sync.sv | 12 +
 rtl/uart_rx_frame.sv | 108 ++++++++++
 tb/tb_uart_rx_frame.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receiver FSM state encoding and default frame geometry
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the serial line, resets to idle-high
module uart_rx_sync (
  input  logic clk_in,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s
);
  logic meta;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) {rx_s, meta} <= 2'b11;
    else {rx_s, meta} <= {meta, rx};
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receive framer with valid/ready byte output
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 parity_error
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  state_t state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic rx_s, bit_end, done, ferr, perr;
  uart_rx_sync u_sync (.clk_in(clk_in), .rst_n(rst_n), .rx(rx), .rx_s(rx_s));
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) par <= 1'b0;
    else par <= (state == PARITY && bit_end) ? rx_s : par;
  assign perr = done & (^{shreg, par});
`else
  localparam state_t AFTER_DATA = STOP;
  assign perr = 1'b0;
`endif
  assign bit_end = baud_tick && tcnt == T_END;
  assign rx_busy = state != IDLE;
  always_comb begin
    state_n = state;
    tcnt_n = baud_tick ? tcnt + 1'b1 : tcnt;
    bcnt_n = bcnt;
    shreg_n = shreg;
    done = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE: begin
        tcnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START:
        if (baud_tick && tcnt == T_MID) begin
          tcnt_n = '0;
          bcnt_n = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      DATA:
        if (bit_end) begin
          tcnt_n = '0;
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          bcnt_n = bcnt + 1'b1;
          if (bcnt == B_LAST) state_n = AFTER_DATA;
        end
      PARITY:
        if (bit_end) begin
          tcnt_n = '0;
          state_n = STOP;
        end
      STOP:
        if (bit_end) begin
          tcnt_n = '0;
          done = rx_s;
          ferr = !rx_s;
          state_n = rx_s ? IDLE : BREAK;
        end
      BREAK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tcnt <= '0;
      bcnt <= '0;
      shreg <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_error <= 1'b0;
      overrun <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      state <= state_n;
      tcnt <= tcnt_n;
      bcnt <= bcnt_n;
      shreg <= shreg_n;
      frame_error <= ferr;
      parity_error <= perr;
      overrun <= done && rx_valid && !rx_ready;
      if (done && (!rx_valid || rx_ready)) rx_data <= shreg;
      rx_valid <= done ? 1'b1 : rx_valid && !rx_ready;
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames against hand-computed results for uart_rx_frame
module tb_uart_rx_frame;
  logic clk_in = 1'b0, rst_n = 1'b1, baud_tick = 1'b0, rx = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, rx_busy, frame_error, overrun, parity_error;
  int total = 0, bad = 0, cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, acc_cnt = 0, vcyc = 0;
  logic [7:0] last_acc = 8'h00;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
  localparam int PE_EXP = 1;
  logic par_flip = 1'b0;
`else
  localparam int NB = 10;
  localparam int PE_EXP = 0;
`endif
  // frames start on a tick edge E0; the stop bit is judged at E0 + DONE_EDGE
  localparam int DONE_EDGE = 28 + 64 * (NB - 1);
  uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_busy(rx_busy),
    .frame_error(frame_error), .overrun(overrun), .parity_error(parity_error)
  );
  always #5 clk_in = ~clk_in;
  initial forever begin
    @(posedge clk_in);
    cyc = cyc + 1;
    #1 baud_tick = (cyc % 4 == 3);
  end
  always @(negedge clk_in) begin
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (parity_error) pe_cnt <= pe_cnt + 1;
    if (rx_valid) vcyc <= vcyc + 1;
    if (rx_valid && rx_ready) begin
      acc_cnt <= acc_cnt + 1;
      last_acc <= rx_data;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    logic [NB-1:0] bits;
    while (cyc % 4 != 0) begin
      @(posedge clk_in);
      #1;
    end
`ifdef UART_RX_PARITY_EN
    bits = {stop_b, (^d) ^ par_flip, d, 1'b0};
`else
    bits = {stop_b, d, 1'b0};
`endif
    for (int i = 0; i < NB; i++) begin
      rx = bits[i];
      wait_cyc(64);
    end
  endtask
  initial begin
    #2 rst_n = 1'b0;
    wait_cyc(3);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_fe", frame_error, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_pe", parity_error, 0);
    @(negedge clk_in) rst_n = 1'b1;
    wait_cyc(8);
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    wait_cyc(4);
    chk("nom_acc", acc_cnt, 1);
    chk("nom_data", last_acc, 8'hA5);
    chk("nom_vcyc", vcyc, 1);
    chk("nom_flags", fe_cnt + ov_cnt + pe_cnt, 0);
    chk("nom_busy", rx_busy, 0);
    chk("nom_valid", rx_valid, 0);
    rx = 1'b0;
    wait_cyc(10);
    chk("fs_busy", rx_busy, 1);
    wait_cyc(10);
    rx = 1'b1;
    wait_cyc(64);
    chk("fs_idle", rx_busy, 0);
    chk("fs_acc", acc_cnt, 1);
    chk("fs_fe", fe_cnt, 0);
    send_frame(8'h3C, 1'b0);
    wait_cyc(64 * 3);
    chk("brk_busy", rx_busy, 1);
    chk("brk_fe", fe_cnt, 1);
    chk("brk_acc", acc_cnt, 1);
    rx = 1'b1;
    wait_cyc(128);
    chk("brk_idle", rx_busy, 0);
    send_frame(8'h81, 1'b1);
    wait_cyc(4);
    chk("brk_next_acc", acc_cnt, 2);
    chk("brk_next_data", last_acc, 8'h81);
    chk("brk_fe_once", fe_cnt, 1);
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    chk("ov_valid1", rx_valid, 1);
    chk("ov_data1", rx_data, 8'h11);
    send_frame(8'h22, 1'b1);
    wait_cyc(4);
    chk("ov_cnt", ov_cnt, 1);
    chk("ov_data_kept", rx_data, 8'h11);
    chk("ov_valid_kept", rx_valid, 1);
    rx_ready = 1'b1;
    wait_cyc(1);
    rx_ready = 1'b0;
    chk("ov_drop", rx_valid, 0);
    chk("ov_acc_data", last_acc, 8'h11);
    chk("ov_acc", acc_cnt, 3);
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        wait_cyc(DONE_EDGE - 1);
        rx_ready = 1'b1;
        @(negedge clk_in);
        chk("sim_pre_data", rx_data, 8'h11);
        wait_cyc(1);
        rx_ready = 1'b0;
        chk("sim_valid", rx_valid, 1);
        chk("sim_data", rx_data, 8'h22);
      end
    join
    chk("sim_no_ov", ov_cnt, 1);
    chk("sim_acc", acc_cnt, 4);
    chk("sim_acc_data", last_acc, 8'h11);
    chk("sim_still_valid", rx_valid, 1);
    rx = 1'b0;
    wait_cyc(200);
    chk("mid_busy", rx_busy, 1);
    @(negedge clk_in) rst_n = 1'b0;
    #1;
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_busy", rx_busy, 0);
    rx = 1'b1;
    @(negedge clk_in) rst_n = 1'b1;
    wait_cyc(8);
    rx_ready = 1'b1;
    send_frame(8'h5A, 1'b1);
    wait_cyc(4);
    chk("post_rst_acc", acc_cnt, 5);
    chk("post_rst_data", last_acc, 8'h5A);
    chk("post_rst_fe", fe_cnt, 1);
    chk("post_rst_ov", ov_cnt, 1);
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    wait_cyc(4);
    chk("par_acc", acc_cnt, 6);
    chk("par_data", last_acc, 8'h07);
`endif
    chk("pe_total", pe_cnt, PE_EXP);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
